// File: rtl/pattern_scan_engine.sv
// Pattern scan engine.
// Reads a 5-bit pattern (top bits of the pattern byte) and a 32-byte string from data memory,
// counts pattern occurrences, then writes three result bytes:
//   RES_ADDR+0 : ctb, matches in windows lying wholly inside one byte
//   RES_ADDR+1 : cto, number of bytes holding at least one in-byte match
//   RES_ADDR+2 : cts, matches over all 252 windows of the 256-bit string (byte 0 = MSB)
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   req_i          start request, only honoured in idle or done
//   done_o         registered completion flag, high while in the done state
//   mem_addr_o     data-memory address
//   mem_rd_data_i  data-memory read data (asynchronous read of mem_addr_o)
//   mem_wr_en_o    data-memory write enable
//   mem_wr_data_o  data-memory write data
module pattern_scan_engine #(
  parameter int unsigned STR_BASE = 0,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned RES_ADDR = 33
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  output logic       done_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rd_data_i,
  output logic       mem_wr_en_o,
  output logic [7:0] mem_wr_data_o
);

  localparam logic [7:0] StrBase8 = 8'(STR_BASE);
  localparam logic [7:0] PatAddr8 = 8'(PAT_ADDR);
  localparam logic [7:0] ResAddr8 = 8'(RES_ADDR);

  typedef enum logic [2:0] {
    StIdle, StRdPat, StScan, StWrB, StWrO, StWrS, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [4:0]  pat_q, pat_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  tail_q, tail_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  cto_q, cto_d;
  logic [7:0]  cts_q, cts_d;

  logic [2:0]  in_cnt;
  logic [2:0]  cross_cnt;

  // Number of the four 5-bit windows of an 8-bit vector that equal the pattern.
  function automatic logic [2:0] count_win(input logic [7:0] x, input logic [4:0] p);
    logic [2:0] c;
    c = 3'd0;
    if (x[4:0] == p) c = c + 3'd1;
    if (x[5:1] == p) c = c + 3'd1;
    if (x[6:2] == p) c = c + 3'd1;
    if (x[7:3] == p) c = c + 3'd1;
    return c;
  endfunction

  // Crossing windows join the previous byte's low nibble with the current high nibble;
  // byte 0 has no predecessor.
  always_comb begin
    in_cnt    = count_win(mem_rd_data_i, pat_q);
    cross_cnt = (idx_q == 5'd0) ? 3'd0 : count_win({tail_q, mem_rd_data_i[7:4]}, pat_q);
  end

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pat_d         = pat_q;
    idx_d         = idx_q;
    tail_d        = tail_q;
    ctb_d         = ctb_q;
    cto_d         = cto_q;
    cts_d         = cts_q;
    mem_addr_o    = 8'd0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = 8'd0;

    unique case (state_q)
      StIdle, StDone: begin
        if (req_i) begin
          state_d = StRdPat;
          done_d  = 1'b0;
          idx_d   = 5'd0;
          tail_d  = 4'd0;
          ctb_d   = 8'd0;
          cto_d   = 8'd0;
          cts_d   = 8'd0;
        end
      end
      StRdPat: begin
        mem_addr_o = PatAddr8;
        pat_d      = mem_rd_data_i[7:3];
        idx_d      = 5'd0;
        state_d    = StScan;
      end
      StScan: begin
        mem_addr_o = StrBase8 + {3'b000, idx_q};
        ctb_d      = ctb_q + {5'b00000, in_cnt};
        cto_d      = cto_q + {7'd0, (in_cnt != 3'd0)};
        cts_d      = cts_q + {5'b00000, in_cnt} + {5'b00000, cross_cnt};
        tail_d     = mem_rd_data_i[3:0];
        idx_d      = idx_q + 5'd1;
        if (idx_q == 5'd31) state_d = StWrB;
      end
      StWrB: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResAddr8;
        mem_wr_data_o = ctb_q;
        state_d       = StWrO;
      end
      StWrO: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResAddr8 + 8'd1;
        mem_wr_data_o = cto_q;
        state_d       = StWrS;
      end
      StWrS: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResAddr8 + 8'd2;
        mem_wr_data_o = cts_q;
        state_d       = StDone;
        done_d        = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      pat_q   <= 5'd0;
      idx_q   <= 5'd0;
      tail_q  <= 4'd0;
      ctb_q   <= 8'd0;
      cto_q   <= 8'd0;
      cts_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      tail_q  <= tail_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: a behavioural memory, a window-by-window reference model
// and a write scoreboard checked whenever the engine drives a memory write.
module tb_pattern_scan_engine;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] str_mem [0:63];   // string and pattern byte, written only by the stimulus
  logic [7:0] res_mem [0:255];  // written only by the engine

  pattern_scan_engine dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .done_o        (done),
    .mem_addr_o    (mem_addr),
    .mem_rd_data_i (mem_rd_data),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_data_o (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = (mem_addr < 8'd33) ? str_mem[mem_addr[5:0]] : 8'h00;

  always @(posedge clk) if (mem_wr_en) res_mem[mem_addr] <= mem_wr_data;

  // Scoreboard: every write the engine makes must match the next expected write.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0d", mem_addr, mem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_wr_data !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                   mem_addr, mem_wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic load(input logic [7:0] pat_byte, input logic [7:0] fill,
                      input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 32; i++) str_mem[i] = fill;
    str_mem[0]  = b0;
    str_mem[1]  = b1;
    str_mem[32] = pat_byte;
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) str_mem[i] = 8'($urandom);
    str_mem[32] = 8'($urandom);
  endtask

  // Reference: slide a 5-bit window over the 256-bit string one bit at a time.
  task automatic model(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
    logic [255:0] s;
    logic [4:0]   p;
    logic [31:0]  hit;
    int           nb, no, ns;
    for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = str_mem[i];
    p   = str_mem[32][7:3];
    hit = '0;
    nb  = 0;
    ns  = 0;
    for (int q = 0; q < 252; q++) begin
      if (s[255 - q -: 5] == p) begin
        ns++;
        if ((q % 8) <= 3) begin
          nb++;
          hit[q / 8] = 1'b1;
        end
      end
    end
    no = 0;
    for (int i = 0; i < 32; i++) if (hit[i]) no++;
    ctb = 8'(nb);
    cto = 8'(no);
    cts = 8'(ns);
  endtask

  // Starts one run, optionally pulsing req again mid-run, and checks latency and results.
  task automatic run_check(input string name, input int extra_req_at);
    logic [7:0] ectb, ecto, ects;
    int n;
    model(ectb, ecto, ects);
    exp_q.push_back({8'd33, ectb});
    exp_q.push_back({8'd34, ecto});
    exp_q.push_back({8'd35, ects});
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_after_req got %b want 0", name, done);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      req = (n == extra_req_at) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    req = 1'b0;
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL %s latency got %0d want 36", name, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (res_mem[33] !== ectb || res_mem[34] !== ecto || res_mem[35] !== ects) begin
      errors++;
      $display("FAIL %s results got %0d/%0d/%0d want %0d/%0d/%0d", name,
               res_mem[33], res_mem[34], res_mem[35], ectb, ecto, ects);
    end
    checks++;
    if (mem_addr !== 8'd0 || mem_wr_data !== 8'd0 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s done_outputs got addr=%0d data=%0d we=%b want 0/0/0", name,
               mem_addr, mem_wr_data, mem_wr_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b1;  // reset must win over req
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got done=%b we=%b addr=%0d data=%0d want 0/0/0/0",
               done, mem_wr_en, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL idle_outputs got done=%b addr=%0d want 0/0", done, mem_addr);
    end
  endtask

  task automatic test_all_zero();
    load(8'h00, 8'h00, 8'h00, 8'h00);
    run_check("all_zero", -1);
    checks++;
    if (res_mem[33] !== 8'd128 || res_mem[34] !== 8'd32 || res_mem[35] !== 8'd252) begin
      errors++;
      $display("FAIL all_zero_const got %0d/%0d/%0d want 128/32/252",
               res_mem[33], res_mem[34], res_mem[35]);
    end
  endtask

  task automatic test_alternating();
    load(8'hA8, 8'h55, 8'h55, 8'h55);
    run_check("alt55", -1);
    checks++;
    if (res_mem[33] !== 8'd64 || res_mem[34] !== 8'd32 || res_mem[35] !== 8'd126) begin
      errors++;
      $display("FAIL alt55_const got %0d/%0d/%0d want 64/32/126",
               res_mem[33], res_mem[34], res_mem[35]);
    end
  endtask

  task automatic test_no_match();
    load(8'hF8, 8'h00, 8'h00, 8'h00);
    run_check("no_match", -1);
  endtask

  task automatic test_crossing();
    load(8'h38, 8'h00, 8'h03, 8'h80);
    run_check("crossing", -1);
    checks++;
    if (res_mem[33] !== 8'd0 || res_mem[34] !== 8'd0 || res_mem[35] !== 8'd1) begin
      errors++;
      $display("FAIL crossing_const got %0d/%0d/%0d want 0/0/1",
               res_mem[33], res_mem[34], res_mem[35]);
    end
  endtask

  task automatic test_reset_mid_scan();
    load(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);           // idle/done -> pattern read
    #1 req = 1'b0;
    @(posedge clk);           // pattern read -> scan
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_scan_reset got done=%b we=%b addr=%0d data=%0d want 0/0/0/0",
               done, mem_wr_en, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL after_abort_done got %b want 0", done);
    end
    run_check("after_abort", -1);
  endtask

  task automatic test_req_during_scan();
    load(8'hA8, 8'h55, 8'h55, 8'h55);
    run_check("req_in_scan", 12);
  endtask

  task automatic test_done_restart();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got %b want 1", done);
    end
    load(8'h38, 8'h00, 8'h03, 8'h80);
    run_check("restart_from_done", -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      load_random();
      run_check("random", -1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    for (int i = 0; i < 64; i++) str_mem[i] = 8'h00;
    test_reset();
    test_all_zero();
    test_alternating();
    test_no_match();
    test_crossing();
    test_reset_mid_scan();
    test_req_during_scan();
    test_done_restart();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
